// File: rtl/flp_adder_normalize_round_pkg.sv
// flp_adder_normalize_round_pkg: shared single-precision widths, packed float type and constants (package flp_pkg).
package flp_pkg;
  localparam int EXPONENT_BITS = 8;
  localparam int SIGNIFICANT_BITS = 23;
  localparam int OVERALL_BITS = 1 + EXPONENT_BITS + SIGNIFICANT_BITS;
  localparam int EXT_SIG_BITS = SIGNIFICANT_BITS + 2;
  localparam int EXP_BIAS = (1 << (EXPONENT_BITS - 1)) - 1;
  localparam logic [EXPONENT_BITS-1:0] EXP_ALL_ONES = {EXPONENT_BITS{1'b1}};
  typedef struct packed {
    logic sign;
    logic [EXPONENT_BITS-1:0] exponent;
    logic [SIGNIFICANT_BITS-1:0] fraction;
  } flp_t;
endpackage

// File: rtl/flp_adder_normalize_round_if.sv
// flp_adder_normalize_round_if: operand bundle from the denorm stage and the packed-result bundle.
interface flp_adder_normalize_round_if;
  import flp_pkg::*;
  logic in_valid;
  logic sign_result;
  logic signs_equal;
  logic bit_shifted_out;
  logic denorm_underflow;
  logic [EXPONENT_BITS-1:0] exponent_b;
  logic [SIGNIFICANT_BITS:0] significant_b;
  logic [SIGNIFICANT_BITS:0] denorm_significant_a;
  logic [OVERALL_BITS-1:0] result;
  logic result_valid;
  logic overflow;
  logic zero;
  modport master (
    output in_valid, sign_result, signs_equal, bit_shifted_out, denorm_underflow,
    output exponent_b, significant_b, denorm_significant_a,
    input result, result_valid, overflow, zero
  );
  modport slave (
    input in_valid, sign_result, signs_equal, bit_shifted_out, denorm_underflow,
    input exponent_b, significant_b, denorm_significant_a,
    output result, result_valid, overflow, zero
  );
endinterface

// File: rtl/flp_adder_normalize_round_lzc.sv
// flp_lzc: combinational leading-zero counter; an all-zero input returns W.
module flp_lzc #(
  parameter int W = 25,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (d[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/flp_adder_normalize_round.sv
// flp_adder_normalize_round: 3-stage add/subtract, normalize and round of pre-aligned significands.
// FLP_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results are truncated.
module flp_adder_normalize_round
  import flp_pkg::*;
#(
  parameter int FLUSH_SUBNORMAL = 0
) (
  input logic clk,
  input logic rst,
  flp_adder_normalize_round_if.slave bus
);
  localparam int EW = EXPONENT_BITS;
  localparam int SW = SIGNIFICANT_BITS;
  localparam int XW = EXT_SIG_BITS;
  localparam int LW = $clog2(XW + 1);
  logic [XW-1:0] ext_a, ext_b;
  logic [XW:0] sum;
  logic s1_valid, s1_sign;
  logic [EW-1:0] s1_exp;
  logic [XW:0] s1_sum;
  assign ext_b = {bus.significant_b, 1'b0};
  assign ext_a = bus.denorm_underflow ? '0 : {bus.denorm_significant_a, bus.bit_shifted_out};
  assign sum = bus.signs_equal ? {1'b0, ext_b} + {1'b0, ext_a} : {1'b0, ext_b} - {1'b0, ext_a};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp <= '0;
      s1_sum <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_sign <= bus.sign_result;
      s1_exp <= bus.exponent_b;
      s1_sum <= sum;
    end
  logic [LW-1:0] lz, sh;
  logic [EW:0] max_sh, n_exp;
  logic [XW-1:0] shifted, n_mant;
  logic carry, n_sticky, n_zero;
  flp_lzc #(.W(XW)) u_lzc (.d(s1_sum[XW-1:0]), .cnt(lz));
  // Left shift stops at effective exponent 1 so tiny results land in the subnormal range
  always_comb begin
    carry = s1_sum[XW];
    max_sh = s1_exp == '0 ? '0 : {1'b0, s1_exp} - 1'b1;
    sh = (EW + 1)'(lz) < max_sh ? lz : max_sh[LW-1:0];
    shifted = s1_sum[XW-1:0] << sh;
    n_mant = carry ? s1_sum[XW:1] : shifted;
    n_sticky = carry & s1_sum[0];
    n_exp = carry ? {1'b0, s1_exp} + 1'b1 : shifted[XW-1] ? {1'b0, s1_exp} - (EW + 1)'(sh) : '0;
    n_zero = s1_sum == '0;
  end
  logic s2_valid, s2_sign, s2_sticky, s2_zero;
  logic [EW:0] s2_exp;
  logic [SW:0] s2_frac;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign <= 1'b0;
      s2_sticky <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp <= '0;
      s2_frac <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sign <= s1_sign;
      s2_sticky <= n_sticky;
      s2_zero <= n_zero;
      s2_exp <= n_exp;
      s2_frac <= n_mant[XW-2:0];
    end
  logic inc, ovf, zr;
  logic [SW:0] f;
  logic [EW:0] e;
  flp_t r;
`ifdef FLP_ROUND_NEAREST_EN
  assign inc = s2_frac[0] & (s2_frac[1] | s2_sticky);
`else
  logic unused_round;
  assign unused_round = s2_frac[0] ^ s2_sticky;
  assign inc = 1'b0;
`endif
  // A carry out of the fraction bumps the exponent, which also promotes a subnormal to normal
  always_comb begin
    f = {1'b0, s2_frac[SW:1]} + {{SW{1'b0}}, inc};
    e = s2_exp + {{EW{1'b0}}, f[SW]};
    ovf = ~s2_zero & (e >= {1'b0, EXP_ALL_ONES});
    zr = s2_zero | (~ovf & (e == '0) & ((f[SW-1:0] == '0) | (FLUSH_SUBNORMAL != 0)));
    r.sign = zr ? 1'b0 : s2_sign;
    r.exponent = zr ? '0 : ovf ? EXP_ALL_ONES : e[EW-1:0];
    r.fraction = zr || ovf ? '0 : f[SW-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.result_valid <= 1'b0;
      bus.result <= '0;
      bus.overflow <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      bus.result_valid <= s2_valid;
      bus.result <= r;
      bus.overflow <= ovf;
      bus.zero <= zr;
    end
endmodule

// File: tb/tb_flp_adder_normalize_round.sv
// tb_flp_adder_normalize_round: scoreboard bench with an exact-arithmetic reference model.
module tb_flp_adder_normalize_round;
  import flp_pkg::*;
  typedef struct {
    logic [31:0] res;
    logic ovf;
    logic zero;
    int cyc;
    int id;
  } exp_t;
`ifdef FLP_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, passed = 0, total = 0, nid = 0;
  exp_t sb[$];
  flp_adder_normalize_round_if bus();
  flp_adder_normalize_round dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(logic [31:0] r, logic o, logic z);
    exp_t x;
    x.res = r; x.ovf = o; x.zero = z; x.cyc = 0; x.id = 0;
    return x;
  endfunction

  // Exact sum in units of 2^-24 of the larger operand's scale, then IEEE-style rounding
  function automatic exp_t model(logic [7:0] eb, logic [23:0] sbv, logic [23:0] a,
                                 logic g, logic eq, logic uf, logic sg);
    longint ea, s, q, rem, half;
    int p, e, d;
    logic inc;
    ea = uf ? 64'd0 : longint'(a) * 2 + longint'(g);
    s = eq ? longint'(sbv) * 2 + ea : longint'(sbv) * 2 - ea;
    if (s == 0) return mk(32'h0, 1'b0, 1'b1);
    p = 0;
    for (int i = 0; i < 26; i++) if (s[i]) p = i;
    e = int'(eb) + p - 24;
    if (e < 1) e = 1;
    d = e - int'(eb) + 1;
    if (d > 0) begin
      q = s >>> d; rem = s - (q <<< d); half = longint'(1) <<< (d - 1);
    end else begin
      q = s <<< (-d); rem = 0; half = 1;
    end
    inc = RNE && ((rem > half) || (rem == half && q[0]));
    q = q + longint'(inc);
    if (q == (longint'(1) <<< 24)) begin e++; q = longint'(1) <<< 23; end
    if (e >= 255) return mk({sg, 8'hFF, 23'h0}, 1'b1, 1'b0);
    if (q < (longint'(1) <<< 23)) e = 0;
    if (e == 0 && q == 0) return mk(32'h0, 1'b0, 1'b1);
    return mk({sg, 8'(e), 23'(q)}, 1'b0, 1'b0);
  endfunction

  task automatic send(input logic [7:0] eb, input logic [23:0] sbv, input logic [23:0] a,
                      input logic g, input logic eq, input logic uf, input logic sg, input exp_t x);
    bus.in_valid = 1'b1;
    bus.exponent_b = eb;
    bus.significant_b = sbv;
    bus.denorm_significant_a = a;
    bus.bit_shifted_out = g;
    bus.signs_equal = eq;
    bus.denorm_underflow = uf;
    bus.sign_result = sg;
    if (!rst) begin x.cyc = cyc; x.id = nid; sb.push_back(x); end
    nid++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [7:0] eb;
    logic [23:0] sbv, a;
    logic g, eq, uf, sg;
    int r, m;
    r = $urandom_range(0, 2);
    eb = r == 0 ? 8'($urandom_range(1, 4)) : r == 1 ? 8'($urandom_range(250, 254)) : 8'($urandom_range(1, 254));
    sbv = 24'($urandom) | 24'h800000;
    m = $urandom_range(0, 3);
    a = m == 0 ? 24'($urandom_range(0, int'(sbv))) : m == 1 ? sbv - 24'($urandom_range(0, 300)) :
        m == 2 ? 24'($urandom_range(0, 15)) : sbv;
    g = 1'($urandom);
    eq = 1'($urandom);
    uf = $urandom_range(0, 7) == 0;
    sg = 1'($urandom);
    if (!eq && !uf && a == sbv) g = 1'b0;
    send(eb, sbv, a, g, eq, uf, sg, model(eb, sbv, a, g, eq, uf, sg));
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({bus.result, bus.result_valid, bus.overflow, bus.zero} !== 35'h0)
      $display("FAIL %s: result=%h valid=%b ovf=%b zero=%b, want all zero", name,
               bus.result, bus.result_valid, bus.overflow, bus.zero);
    else passed++;
  endtask

  always @(negedge clk)
    if (!rst && bus.result_valid) begin
      total++;
      if (sb.size() == 0) $display("FAIL unexpected_valid: result=%h at cycle %0d, want no valid", bus.result, cyc);
      else begin
        exp_t x;
        x = sb.pop_front();
        if (bus.result !== x.res || bus.overflow !== x.ovf || bus.zero !== x.zero || cyc != x.cyc + 3)
          $display("FAIL op%0d: result=%h ovf=%b zero=%b cycle=%0d, want result=%h ovf=%b zero=%b cycle=%0d",
                   x.id, bus.result, bus.overflow, bus.zero, cyc, x.res, x.ovf, x.zero, x.cyc + 3);
        else passed++;
      end
    end

  initial begin
    bus.in_valid = 1'b0;
    bus.sign_result = 1'b0;
    bus.signs_equal = 1'b0;
    bus.bit_shifted_out = 1'b0;
    bus.denorm_underflow = 1'b0;
    bus.exponent_b = '0;
    bus.significant_b = '0;
    bus.denorm_significant_a = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b0;
    send(8'd127, 24'h800000, 24'h800000, 0, 1, 0, 0, mk(32'h40000000, 0, 0));
    send(8'd127, 24'h800000, 24'h800000, 0, 0, 0, 0, mk(32'h00000000, 0, 1));
    send(8'd254, 24'hFFFFFF, 24'hFFFFFF, 0, 1, 0, 0, mk(32'h7F800000, 1, 0));
    send(8'd127, 24'h800000, 24'h000001, 1, 1, 0, 0, mk(RNE ? 32'h3F800002 : 32'h3F800001, 0, 0));
    send(8'd127, 24'h800000, 24'h000000, 1, 1, 0, 0, mk(32'h3F800000, 0, 0));
    send(8'd130, 24'hC00000, 24'($urandom), 1'($urandom), 1, 1, 0, mk(32'h41400000, 0, 0));
    send(8'd130, 24'hC00000, 24'($urandom), 1'($urandom), 0, 1, 0, mk(32'h41400000, 0, 0));
    send(8'd1, 24'h800000, 24'h7FFFFF, 0, 0, 0, 0, mk(32'h00000001, 0, 0));
    send(8'd127, 24'hFFFFFF, 24'h000000, 1, 1, 0, 0, mk(RNE ? 32'h40000000 : 32'h3FFFFFFF, 0, 0));
    send(8'd254, 24'hFFFFFF, 24'h000000, 1, 1, 0, 1, RNE ? mk(32'hFF800000, 1, 0) : mk(32'hFF7FFFFF, 0, 0));
    for (int i = 0; i < 300; i++) begin
      send_rand();
      if ($urandom_range(0, 5) == 0) begin @(posedge clk); #1; end
    end
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        rst = 1'b1;
        sb.delete();
        #1;
        check_reset("async_reset_clear");
      end
      if (i == 3) rst = 1'b0;
      send_rand();
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      total++;
      $display("FAIL timeout op%0d: no result_valid, want result=%h", x.id, x.res);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
